// File: rtl/imem_loader_if.sv
// Byte-stream receive side and instruction-memory write side of the boot loader.
// The slave modport is the loader's view; the master modport is the view of the
// stream source and memory model that connect to it.
interface imem_loader_if;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        im_we_o;
  logic [31:0] im_addr_o;
  logic [31:0] im_data_o;

  modport slave (
    input  rx_data_i,
    input  rx_valid_i,
    output rx_ready_o,
    output im_we_o,
    output im_addr_o,
    output im_data_o
  );

  modport master (
    output rx_data_i,
    output rx_valid_i,
    input  rx_ready_o,
    input  im_we_o,
    input  im_addr_o,
    input  im_data_o
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Frame: 0xA5, 16-bit big-endian word count N, 4*N data bytes (MSB first),
// then an optional XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
// Each completed word is written with a one-cycle strobe to consecutive word
// addresses; the CPU reset (active-low) is released one cycle after the last
// write so the CPU never runs while the final word is still being stored.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          MAX_WORDS = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  imem_loader_if.slave bus,
  output logic         cpu_rst_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERROR
  } state_t;

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic        im_we_q, im_we_d;
  logic [31:0] im_addr_q, im_addr_d;
  logic [31:0] im_data_q, im_data_d;
  logic        cpu_rst_q, cpu_rst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        rx_ready;
  logic        accept;
  logic [15:0] new_len;
  state_t      final_state;

  assign rx_ready     = (state_q != DONE) && (state_q != ERROR);
  assign accept       = bus.rx_valid_i && rx_ready;
  assign new_len      = {len_q[15:8], bus.rx_data_i};
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign final_state  = CSUM;
`else
  assign final_state  = DONE;
`endif

  assign bus.rx_ready_o = rx_ready;
  assign bus.im_we_o    = im_we_q;
  assign bus.im_addr_o  = im_addr_q;
  assign bus.im_data_o  = im_data_q;
  assign cpu_rst_o      = cpu_rst_q;
  assign done_o         = (state_q == DONE);
  assign err_o          = (state_q == ERROR);
  assign busy_o         = (state_q != IDLE) && (state_q != DONE) && (state_q != ERROR);

  // Frame parser: next state, word assembly and write-strobe generation.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    shift_d    = shift_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_data_d  = im_data_q;
    cpu_rst_d  = (state_q == DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    if (accept && ((state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == DATA))) begin
      csum_d = csum_q ^ bus.rx_data_i;
    end
`endif
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (bus.rx_data_i == 8'hA5) begin
            state_d = HDR_HI;
          end
        end
        HDR_HI: begin
          len_d   = {bus.rx_data_i, 8'h00};
          state_d = HDR_LO;
        end
        HDR_LO: begin
          len_d      = new_len;
          byte_cnt_d = 2'd0;
          word_cnt_d = 16'd0;
          if ({1'b0, new_len} > MAX_N) begin
            state_d = ERROR;
          end else if (new_len == 16'd0) begin
            state_d = final_state;
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          shift_d    = {shift_q[15:0], bus.rx_data_i};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            im_we_d    = 1'b1;
            im_data_d  = {shift_q, bus.rx_data_i};
            im_addr_d  = BASE_ADDR + {14'd0, word_cnt_q, 2'b00};
            word_cnt_d = word_cnt_q + 16'd1;
            if (word_cnt_q == (len_q - 16'd1)) begin
              state_d = final_state;
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          state_d = (bus.rx_data_i == csum_q) ? DONE : ERROR;
        end
`endif
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      len_q      <= 16'd0;
      byte_cnt_q <= 2'd0;
      word_cnt_q <= 16'd0;
      shift_q    <= 24'd0;
      im_we_q    <= 1'b0;
      im_addr_q  <= BASE_ADDR;
      im_data_q  <= 32'd0;
      cpu_rst_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      shift_q    <= shift_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_data_q  <= im_data_d;
      cpu_rst_q  <= cpu_rst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: drives framed byte streams, keeps a queue of
// expected {address, data} writes and compares every im_we_o strobe against it.
module tb_imem_loader;
  localparam logic [31:0] BASE = 32'd0;
  localparam int          MAXW = 32;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic cpuRst, busy, done, err;

  imem_loader_if bus();

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk_i    (clk),
    .rst_i    (rstN),
    .bus      (bus),
    .cpu_rst_o(cpuRst),
    .busy_o   (busy),
    .done_o   (done),
    .err_o    (err)
  );

  always #5 clk = ~clk;

  int          checkCount = 0;
  int          errorCount = 0;
  bit          randomValid = 1'b0;
  logic [31:0] frameWords[$];
  logic [63:0] expQ[$];

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rstN && bus.im_we_o === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write", 32'd1, 32'd0);
      end else begin
        logic [63:0] e;
        e = expQ.pop_front();
        checkOutput("write_addr", bus.im_addr_o, e[63:32]);
        checkOutput("write_data", bus.im_data_o, e[31:0]);
      end
    end
  end

  // Reset for one edge and confirm the reset values of all outputs.
  task automatic doReset();
    @(negedge clk);
    rstN = 1'b0;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i = 8'h00;
    @(negedge clk);
    checkOutput("rst_rx_ready", 32'(bus.rx_ready_o), 32'd1);
    checkOutput("rst_im_we", 32'(bus.im_we_o), 32'd0);
    checkOutput("rst_im_addr", bus.im_addr_o, BASE);
    checkOutput("rst_im_data", bus.im_data_o, 32'd0);
    checkOutput("rst_cpu_rst", 32'(cpuRst), 32'd0);
    checkOutput("rst_flags", {29'd0, busy, done, err}, 32'd0);
    rstN = 1'b1;
  endtask

  // Offer one byte until accepted; returns at the negedge after the transfer.
  task automatic sendByte(input logic [7:0] b);
    int  guard;
    bit  acc;
    if (randomValid) begin
      repeat ($urandom_range(0, 2)) begin
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i = 8'($urandom);
        @(negedge clk);
      end
    end
    bus.rx_data_i = b;
    bus.rx_valid_i = 1'b1;
    guard = 0;
    acc = 1'b0;
    while (!acc && guard < 20) begin
      acc = bus.rx_ready_o;
      @(negedge clk);
      guard++;
    end
    bus.rx_valid_i = 1'b0;
    if (!acc) checkOutput("rx_accept_timeout", 32'd0, 32'd1);
  endtask

  // Send a frame built from frameWords, queuing the expected writes.
  task automatic applyStimulus(input logic [15:0] nLen, input bit sendData,
                               input bit sendCsum, input bit badCsum);
    logic [7:0] csum;
    logic [7:0] b;
    csum = 8'h00;
    sendByte(8'hA5);
    sendByte(nLen[15:8]);
    csum ^= nLen[15:8];
    checkOutput("busy_in_header", 32'(busy), 32'd1);
    sendByte(nLen[7:0]);
    csum ^= nLen[7:0];
    if (sendData) begin
      for (int w = 0; w < frameWords.size(); w++) begin
        for (int k = 0; k < 4; k++) begin
          b = frameWords[w][31 - 8*k -: 8];
          if (k == 3) expQ.push_back({BASE + 32'(w) * 32'd4, frameWords[w]});
          sendByte(b);
          csum ^= b;
        end
      end
    end
    if (sendCsum && CSUM_EN) sendByte(badCsum ? 8'h00 : csum);
  endtask

  // Check end-of-frame status and the one-cycle-late CPU release.
  task automatic checkFinish(input bit expDone, input bit expErr);
    checkOutput("end_done", 32'(done), 32'(expDone));
    checkOutput("end_err", 32'(err), 32'(expErr));
    checkOutput("end_rx_ready", 32'(bus.rx_ready_o), 32'd0);
    checkOutput("end_busy", 32'(busy), 32'd0);
    checkOutput("cpu_rst_during_last", 32'(cpuRst), 32'd0);
    @(negedge clk);
    checkOutput("cpu_rst_after", 32'(cpuRst), 32'(expDone));
    repeat (2) @(negedge clk);
    checkOutput("cpu_rst_hold", 32'(cpuRst), 32'(expDone));
    checkOutput("pending_writes", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    bus.rx_data_i = 8'h00;
    bus.rx_valid_i = 1'b0;

    // Test 1: two-word image.
    doReset();
    frameWords = '{32'h20080005, 32'h01095020};
    applyStimulus(16'd2, 1'b1, 1'b1, 1'b0);
    checkFinish(1'b1, 1'b0);

    // Test 2: garbage before sync, then an empty image.
    doReset();
    frameWords = {};
    sendByte(8'h00);
    sendByte(8'hFF);
    checkOutput("idle_after_garbage", 32'(busy), 32'd0);
    applyStimulus(16'd0, 1'b0, 1'b1, 1'b0);
    checkFinish(1'b1, 1'b0);

    // Test 3: one word over the limit is rejected.
    doReset();
    applyStimulus(16'(MAXW + 1), 1'b0, 1'b0, 1'b0);
    checkFinish(1'b0, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Test 4: bad checksum keeps the CPU in reset after writing.
    doReset();
    frameWords = '{32'h20080005, 32'h01095020};
    applyStimulus(16'd2, 1'b1, 1'b1, 1'b1);
    checkFinish(1'b0, 1'b1);
`endif

    // Test 5: reset mid-word, then a clean one-word frame.
    doReset();
    sendByte(8'hA5);
    sendByte(8'h00);
    sendByte(8'h01);
    sendByte(8'h12);
    sendByte(8'h34);
    doReset();
    frameWords = '{32'hDEADBEEF};
    applyStimulus(16'd1, 1'b1, 1'b1, 1'b0);
    checkFinish(1'b1, 1'b0);

    // Test 6: test 1 with random gaps in rx_valid_i.
    doReset();
    randomValid = 1'b1;
    frameWords = '{32'h20080005, 32'h01095020};
    applyStimulus(16'd2, 1'b1, 1'b1, 1'b0);
    checkFinish(1'b1, 1'b0);
    randomValid = 1'b0;

    // Boundary: exactly MAX_WORDS words fills memory up to the last address.
    doReset();
    frameWords = {};
    for (int i = 0; i < MAXW; i++) frameWords.push_back($urandom);
    applyStimulus(16'(MAXW), 1'b1, 1'b1, 1'b0);
    checkFinish(1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

  // Watchdog so a stuck run still ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout checks=%0d errors=%0d", checkCount, errorCount);
    $fatal(1, "[TB] timeout");
  end

endmodule
